// File: rtl/pipelined_reg_file.sv
// Parametrised dual-write, multi-read register file with registered reads,
// write-first bypass, optional zero register and a reset-driven clear engine.
module pipelined_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       CLK_RegFile,
  input  logic                       RST_RegFile,
  input  logic [NUM_RD-1:0]          RE,
  input  logic [NUM_RD*ADDR_W-1:0]   RA,
  output logic [NUM_RD*DATA_W-1:0]   RD,
  input  logic                       WE0,
  input  logic [ADDR_W-1:0]          WA0,
  input  logic [DATA_W-1:0]          WD0,
  input  logic                       WE1,
  input  logic [ADDR_W-1:0]          WA1,
  input  logic [DATA_W-1:0]          WD1,
  output logic                       BUSY,
  output logic                       CLR_DONE
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                w0_ok;
  logic                w1_ok;
  logic [NUM_RD*DATA_W-1:0] rd_nx;

  // Writes to entry 0 vanish when it is hardwired to zero
  assign w0_ok = WE0 && !((ZERO_REG != 0) && (WA0 == '0));
  assign w1_ok = WE1 && !((ZERO_REG != 0) && (WA1 == '0));

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] nx;
    assign a  = RA[k*ADDR_W +: ADDR_W];
    assign nx = ((ZERO_REG != 0) && (a == '0)) ? '0 :
                (w1_ok && (WA1 == a))          ? WD1 :
                (w0_ok && (WA0 == a))          ? WD0 :
                mem[a];
    assign rd_nx[k*DATA_W +: DATA_W] = nx;
  end

  always_ff @(posedge CLK_RegFile) begin
    if (RST_RegFile) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        if (w0_ok) mem[WA0] <= WD0;
        if (w1_ok) mem[WA1] <= WD1;
      end
    end
  end

  always_ff @(posedge CLK_RegFile) begin
    if (!RST_RegFile) begin
      state    <= CLEAR;
      cnt      <= '0;
      RD       <= '0;
      BUSY     <= 1'b1;
      CLR_DONE <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == ADDR_W'(DEPTH - 1)) begin
        state    <= READY;
        BUSY     <= 1'b0;
        CLR_DONE <= 1'b1;
      end
    end else begin
      CLR_DONE <= 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
        if (RE[k]) RD[k*DATA_W +: DATA_W] <= rd_nx[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_reg_file.sv
// Scoreboard bench: two instances (zero register on/off) driven in lockstep
// against an array-based reference model.
module tb_pipelined_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] re  = '0;
  logic [NR*AW-1:0] ra = '0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] wa0 = '0, wa1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;

  logic [NR*DW-1:0] rd_z, rd_n;
  logic busy_z, busy_n, done_z, done_n;

  always #5 clk = ~clk;

  pipelined_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_z (
    .CLK_RegFile(clk), .RST_RegFile(rst), .RE(re), .RA(ra), .RD(rd_z),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .BUSY(busy_z), .CLR_DONE(done_z));

  pipelined_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_n (
    .CLK_RegFile(clk), .RST_RegFile(rst), .RE(re), .RA(ra), .RD(rd_n),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .BUSY(busy_n), .CLR_DONE(done_n));

  typedef struct {
    int          due;
    int          d;
    int          k;
    logic [DW-1:0] v;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [DW-1:0] m [2][DEPTH];
  logic [DW-1:0] h [2][NR];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expected RD value carries the edge it is due after
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [DW-1:0] act;
      e = q.pop_front();
      act = (e.d == 0) ? rd_z[e.k*DW +: DW] : rd_n[e.k*DW +: DW];
      checks++;
      if (e.due != cyc || act !== e.v) begin
        errors++;
        $display("FAIL rd zr=%0d port%0d cyc%0d: got %h expected %h",
                 1 - e.d, e.k, cyc, act, e.v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, queue expected RD
  task automatic step(input bit ready);
    for (int d = 0; d < 2; d++) begin
      bit zr;
      zr = (d == 0);
      if (ready) begin
        if (we0 && !(zr && wa0 == 0)) m[d][wa0] = wd0;
        if (we1 && !(zr && wa1 == 0)) m[d][wa1] = wd1;
      end
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] a;
        a = ra[k*AW +: AW];
        if (!ready) h[d][k] = '0;
        else if (re[k]) h[d][k] = (zr && a == 0) ? '0 : m[d][a];
        q.push_back('{due: cyc + 1, d: d, k: k, v: h[d][k]});
      end
    end
    @(posedge clk);
    #1;
    if (done_z) pulses++;
  endtask

  task automatic rand_in(input int amax);
    re  = NR'($urandom);
    ra  = {AW'($urandom_range(amax)), AW'($urandom_range(amax))};
    we0 = 1'($urandom);
    we1 = 1'($urandom);
    wa0 = AW'($urandom_range(amax));
    wa1 = AW'($urandom_range(amax));
    wd0 = $urandom;
    wd1 = $urandom;
  endtask

  task automatic clr_cycle();
    rand_in(31);
    we0 = 1'b1; wa0 = 3; wd0 = 32'hABCD0000;
    step(0);
  endtask

  task automatic clear_seq(input int restart_at);
    int n;
    pulses = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) m[d][i] = '0;
    rst = 1'b0;
    repeat (3) clr_cycle();
    check("busy_in_reset", {31'd0, busy_z}, 32'd1);
    check("done_in_reset", {31'd0, done_z}, 32'd0);
    rst = 1'b1;
    if (restart_at > 0) begin
      repeat (restart_at) clr_cycle();
      rst = 1'b0;
      clr_cycle();
      rst = 1'b1;
      check("busy_after_restart", {31'd0, busy_z}, 32'd1);
    end
    n = 0;
    do begin
      clr_cycle();
      n++;
    end while (busy_z && n < 100);
    check("clear_cycles", n, DEPTH);
    check("done_pulse_z", {31'd0, done_z}, 32'd1);
    check("done_pulse_n", {31'd0, done_n}, 32'd1);
    check("busy_n_low", {31'd0, busy_n}, 32'd0);
    re = '0; we0 = 0; we1 = 0;
    step(1);
    check("done_low_after", {31'd0, done_z | done_n}, 32'd0);
    check("busy_low_after", {31'd0, busy_z | busy_n}, 32'd0);
    check("pulse_count", pulses, 1);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; re = '0;
  endtask

  initial begin
    clear_seq(0);

    // every address reads 0 after the clear
    idle();
    for (int i = 0; i < DEPTH; i += 2) begin
      re = 2'b11;
      ra = {AW'(i + 1), AW'(i)};
      step(1);
    end

    // basic write then read
    idle(); we0 = 1; wa0 = 7; wd0 = 32'hDEADBEEF; step(1);
    idle(); re = 2'b11; ra = {AW'(8), AW'(7)}; step(1);

    // same-address collision with same-cycle bypass
    idle();
    we0 = 1; wa0 = 5; wd0 = 32'h11111111;
    we1 = 1; wa1 = 5; wd1 = 32'h22222222;
    re = 2'b01; ra = {AW'(0), AW'(5)};
    step(1);
    idle(); re = 2'b10; ra = {AW'(5), AW'(1)}; step(1);

    // entry 0 write with same-cycle read, then a later read
    idle(); we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF;
    re = 2'b01; ra = {AW'(2), AW'(0)}; step(1);
    idle(); re = 2'b11; ra = {AW'(0), AW'(0)}; step(1);

    // RD port 1 holds while its address moves
    idle(); re = 2'b11; ra = {AW'(7), AW'(5)}; step(1);
    for (int i = 0; i < 4; i++) begin
      idle(); re = 2'b01; ra = {AW'(i), AW'(i + 4)}; step(1);
    end

    // random traffic over a narrow address range for collisions
    for (int i = 0; i < 300; i++) begin
      rand_in(i < 150 ? 7 : 31);
      step(1);
    end

    // blocked write during clear, restart mid-clear
    clear_seq(10);
    idle(); re = 2'b11; ra = {AW'(7), AW'(3)}; step(1);
    for (int i = 0; i < 100; i++) begin
      rand_in(7);
      step(1);
    end

    idle();
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_reg_file.md
Name: pipelined_reg_file

Overview:
- Parametrised successor to the single-write, two-read register file used in the pipelined MIPS core.
- Adds configurable width, depth and read-port count, plus a second write port for a dual-issue writeback.
- Adds write-first bypass, optional hardwired zero register, and a sequential clear engine driven by reset.
- Reads are registered, with a fixed latency of one clock.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register

Ports:
CLK_RegFile  in  1  clock; all state updates on the rising edge
RST_RegFile  in  1  synchronous, active-low reset
RE  in  NUM_RD  per-port read enable
RA  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
RD  out  NUM_RD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W]
WE0  in  1  write enable, port 0
WA0  in  ADDR_W  write address, port 0
WD0  in  DATA_W  write data, port 0
WE1  in  1  write enable, port 1
WA1  in  ADDR_W  write address, port 1
WD1  in  DATA_W  write data, port 1
BUSY  out  1  high while the clear engine runs; writes and reads are blocked
CLR_DONE  out  1  one-cycle pulse when the clear completes

Behaviour:
- FSM states are CLEAR and READY. A rising edge with RST_RegFile=0 forces CLEAR, sets the clear counter cnt to 0, sets RD to all zeros, sets BUSY=1 and sets CLR_DONE=0.
- CLEAR, each cycle with RST_RegFile=1:
  - Writes 0 into entry cnt, then increments cnt.
  - When cnt == DEPTH-1, writes that entry, moves to READY and asserts CLR_DONE for exactly one cycle.
  - The clear takes exactly DEPTH cycles after reset deasserts.
  - Reset reasserted mid-clear restarts cnt at 0.
- In CLEAR:
  - WE0 and WE1 are ignored.
  - RE is ignored; RD holds 0.
  - BUSY=1.
- READY, writes:
  - On a rising edge with WEx=1, the entry at WAx takes WDx.
  - If WE0 and WE1 are both set and WA0 == WA1, port 1 wins and the port 0 data is discarded.
  - If ZERO_REG=1, writes to address 0 are dropped.
- READY, reads:
  - For port k with RE[k]=1, RD slice k at the next rising edge takes the value of entry RA[k] as it is after this edge's writes (write-first).
  - Bypass priority:
    - If WE1=1, WA1 == RA[k] and the write is not dropped, RD takes WD1.
    - Otherwise, under the same condition for port 0, RD takes WD0.
    - Otherwise RD takes the stored entry.
  - If ZERO_REG=1 and RA[k] == 0, RD slice k takes 0.
  - RE[k]=0 leaves slice k holding its previous value.
  - Read latency is one cycle from address to RD; there are no combinational paths from inputs to outputs.
- BUSY=0 and CLR_DONE=0 in READY, apart from the single CLR_DONE pulse on entry.
- All read ports are independent; any number of ports may read the same address in the same cycle.
- Outputs are reset to: RD=0, BUSY=1, CLR_DONE=0.

Test Plan:
- Clear sequence: hold RST_RegFile=0 for 3 cycles, then release -> BUSY=1 for exactly 32 cycles, CLR_DONE pulses one cycle as BUSY falls, and reading every address afterwards returns 0x00000000.
- Basic write and read:
  - Write 0xDEADBEEF to address 7 via port 0.
  - Next cycle, RA port 0 = 7 with RE=1 -> RD port 0 = 0xDEADBEEF one cycle later.
  - Port 1 reading address 8 returns 0.
- Bypass and collision:
  - Same cycle: WE0 writes 0x11111111 to address 5, WE1 writes 0x22222222 to address 5, RA port 0 = 5 with RE=1.
  - Required: RD port 0 = 0x22222222, and a later read of address 5 returns 0x22222222.
- Zero register:
  - With ZERO_REG=1, write 0xFFFFFFFF to address 0 with a same-cycle read of address 0 -> RD = 0, and a later read also returns 0.
  - With ZERO_REG=0, the same stimulus -> RD = 0xFFFFFFFF on both reads.
- Blocked access and hold:
  - During CLEAR, assert WE0 to address 3 with data 0xABCD0000 -> after the clear, address 3 reads 0.
  - In READY, drop RE[1] -> RD port 1 holds its last value while RA[1] changes.
- Mid-clear reset:
  - Pulse RST_RegFile low at clear cycle 10 -> the clear restarts, BUSY stays high for another full 32 cycles, and CLR_DONE pulses exactly once.
